camera_frame_capture: RTL
=========================

Name: camera_frame_capture

Overview:
Parametrised camera pixel-capture front end for OV7670-class parallel sensors. Generates the sensor master clock (XLK) and synchronises PLK/VS/HS/D into the i_Clk domain. Assembles 1- or 2-byte pixels into words and writes one frame per VS period into a frame RAM. Reports frame completion, frame count and sticky length errors to the downstream frame-buffer/display logic.

Parameters:
DATA_W, 8, sensor data bus width
ADDR_W, 15, RAM address width
FRAME_PIXELS, 9216, expected pixels per frame; max write address is FRAME_PIXELS-1
XCLK_HALF, 5, i_Clk cycles per XLK half-period (must be >=1)
SYNC_STAGES, 2, synchroniser depth for PLK/VS/HS/D (must be >=2)

Ports:
i_Clk  in  1  system clock
i_Rst_n  in  1  asynchronous active-low reset
i_Enable  in  1  capture enable (level)
i_Mode  in  1  0 = 1 byte/pixel; 1 = 2 bytes/pixel (RGB565, first byte high)
i_Clear_Err  in  1  clears o_Error (single-cycle pulse)
o_XLK  out  1  sensor master clock
i_PLK  in  1  sensor pixel clock (asynchronous)
i_VS  in  1  sensor vertical sync, high = blanking
i_HS  in  1  sensor href, high = valid line data
i_D  in  DATA_W  sensor data
o_RAM_Data  out  2*DATA_W  pixel word
o_RAM_Address  out  ADDR_W  pixel index
o_RAM_Write_Enable  out  1  one-cycle write strobe
o_Frame_Done  out  1  one-cycle pulse at end of a captured frame
o_Frame_Count  out  8  captured-frame counter, wraps 255->0
o_Error  out  1  sticky: overflow or short frame

Behaviour:
- Reset: all outputs 0 except o_XLK = 1; state IDLE; byte phase 0; pixel index 0.
- XLK: counter 0..XCLK_HALF-1; o_XLK toggles on wrap; free-runs regardless of i_Enable or state (sensor needs XLK for SCCB config).
- PLK, VS, HS and D pass through SYNC_STAGES flops. The PLK rising edge is detected from the last two stages. VS/HS/D are taken from the same stage as the PLK edge.
- States:
  - IDLE -> WAIT_VS when i_Enable=1.
  - WAIT_VS -> CAPTURE on the VS falling edge (start of a frame). If i_Enable=0 while in WAIT_VS -> IDLE immediately.
  - CAPTURE -> WAIT_VS on the VS rising edge, or -> IDLE if i_Enable=0 at that edge. Deasserting i_Enable mid-frame never truncates the frame.
- CAPTURE byte rule: on a PLK edge with VS=0 and HS=1, accept the byte.
  - Mode 0: write {0, byte}.
  - Mode 1: phase 0 latches the high byte; phase 1 writes {hi, byte}.
  - The HS falling edge resets the phase to 0; an odd trailing byte is discarded.
- i_Mode is sampled at the VS falling edge and held for the whole frame.
- Write: o_RAM_Write_Enable is high exactly one cycle, the cycle after the accepting edge, with o_RAM_Data and o_RAM_Address valid. The address is the pixel index, which then increments.
- Latency from PLK rise to strobe: SYNC_STAGES+2 i_Clk cycles. PLK must be at most i_Clk/4.
- Overflow: a pixel completed at index = FRAME_PIXELS gets no strobe; set o_Error and drop the rest of the frame.
- Frame end: on the VS rising edge in CAPTURE, o_Frame_Done pulses for one cycle and o_Frame_Count increments. If the pixel count != FRAME_PIXELS, set o_Error. Then reset pixel index and phase to 0.
- o_Error: i_Clear_Err clears it. A simultaneous set and clear leaves it set.
- An async reset mid-frame aborts the frame with no o_Frame_Done. After reset the block waits for the next full VS falling edge.

Decomposition:
- Package camera_pkg holds:
  - state enum (IDLE, WAIT_VS, CAPTURE)
  - mode constants MODE_Y8 = 0 and MODE_RGB565 = 1
  - default FRAME_PIXELS
- Sub-module cam_sync_edge: SYNC_STAGES synchroniser with rise/fall outputs, instantiated for PLK, VS and HS.

Test Plan:
1. XLK: reset, XCLK_HALF=5 -> o_XLK=1 after reset, toggles every 5 i_Clk (period 10) with i_Enable=0.
2. Mode 0 frame: FRAME_PIXELS=16, VS falls, 4 lines of 4 bytes 0x00..0x0F -> 16 strobes, addresses 0..15, data 0x0000..0x000F, o_Frame_Done once, o_Frame_Count=1, o_Error=0.
3. Mode 1 pairing: bytes 0xAB, 0xCD, 0x12, 0x34 -> writes 0xABCD@0 and 0x1234@1. A line of 3 bytes 0x11,0x22,0x33 -> one write 0x1122; 0x33 is dropped and the next line starts at phase 0.
4. Overflow and short frame: 18 pixels with FRAME_PIXELS=16 -> exactly 16 strobes, o_Error=1. After i_Clear_Err, a 10-pixel frame -> o_Error=1 and o_Frame_Done still pulses.
5. Enable handling: i_Enable drops mid-frame -> the frame completes, then IDLE with no further strobes. Enable asserted mid-frame (VS low) -> no writes until the next VS fall.
6. Reset mid-frame: i_Rst_n low for 3 cycles at pixel 7 -> outputs return to reset values with no o_Frame_Done. The next frame writes from address 0 and o_Frame_Count=1 after it.

Source files
------------

// File: rtl/camera_pkg.sv
// Shared types and constants for the OV7670-class camera capture front end.
package camera_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2
  } cam_state_e;

  localparam logic MODE_Y8     = 1'b0;
  localparam logic MODE_RGB565 = 1'b1;

  localparam int DEF_FRAME_PIXELS = 9216;

endpackage

// File: rtl/cam_sync_edge.sv
// Multi-stage synchroniser for one asynchronous sensor line, with registered
// level and rise/fall strobes that are aligned with each other.
module cam_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              level_q;
  logic              rise_q;
  logic              fall_q;

  // The compare stage doubles as the level output so edge and level refer to the same sample.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], async_i};
      level_q <= sync_q[STAGES-1];
      rise_q  <= sync_q[STAGES-1] & ~level_q;
      fall_q  <= ~sync_q[STAGES-1] & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/camera_frame_capture.sv
// Camera pixel-capture front end: XLK generation, input synchronisation,
// byte-to-pixel assembly and frame RAM write sequencing with error reporting.
module camera_frame_capture
  import camera_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 15,
  parameter int FRAME_PIXELS = DEF_FRAME_PIXELS,
  parameter int XCLK_HALF    = 5,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  input  logic                i_Enable,
  input  logic                i_Mode,
  input  logic                i_Clear_Err,
  output logic                o_XLK,
  input  logic                i_PLK,
  input  logic                i_VS,
  input  logic                i_HS,
  input  logic [DATA_W-1:0]   i_D,
  output logic [2*DATA_W-1:0] o_RAM_Data,
  output logic [ADDR_W-1:0]   o_RAM_Address,
  output logic                o_RAM_Write_Enable,
  output logic                o_Frame_Done,
  output logic [7:0]          o_Frame_Count,
  output logic                o_Error
);

  localparam int               PIX_W    = ADDR_W + 1;
  localparam int               XC_W     = (XCLK_HALF > 1) ? $clog2(XCLK_HALF) : 1;
  localparam logic [XC_W-1:0]  XC_LAST  = XC_W'(XCLK_HALF - 1);
  localparam logic [PIX_W-1:0] PIX_FULL = PIX_W'(FRAME_PIXELS);

  logic [XC_W-1:0]     xclk_cnt_q;
  logic                xlk_q;
  logic [DATA_W-1:0]   d_sync_q [SYNC_STAGES+1];

  logic                plk_rise_s;
  logic                unused_plk_lvl_s;
  logic                unused_plk_fall_s;
  logic                vs_lvl_s;
  logic                vs_rise_s;
  logic                vs_fall_s;
  logic                hs_lvl_s;
  logic                hs_rise_s;
  logic                hs_fall_s;
  logic [DATA_W-1:0]   byte_s;

  cam_state_e          state_q;
  logic                mode_q;
  logic                phase_q;
  logic [DATA_W-1:0]   hi_q;
  logic [PIX_W-1:0]    pix_q;
  logic                drop_q;
  logic                we_q;
  logic [2*DATA_W-1:0] data_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                done_q;
  logic [7:0]          fcnt_q;
  logic                err_q;

  logic                byte_ok_s;
  logic                pix_done_s;
  logic [2*DATA_W-1:0] word_d;

  // XLK keeps running in every state so the sensor can be configured over SCCB.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      xclk_cnt_q <= '0;
      xlk_q      <= 1'b1;
    end else if (xclk_cnt_q == XC_LAST) begin
      xclk_cnt_q <= '0;
      xlk_q      <= ~xlk_q;
    end else begin
      xclk_cnt_q <= xclk_cnt_q + XC_W'(1);
    end
  end

  cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_plk (
    .clk_i   (i_Clk),
    .rst_n_i (i_Rst_n),
    .async_i (i_PLK),
    .level_o (unused_plk_lvl_s),
    .rise_o  (plk_rise_s),
    .fall_o  (unused_plk_fall_s)
  );

  cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_vs (
    .clk_i   (i_Clk),
    .rst_n_i (i_Rst_n),
    .async_i (i_VS),
    .level_o (vs_lvl_s),
    .rise_o  (vs_rise_s),
    .fall_o  (vs_fall_s)
  );

  cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_hs (
    .clk_i   (i_Clk),
    .rst_n_i (i_Rst_n),
    .async_i (i_HS),
    .level_o (hs_lvl_s),
    .rise_o  (hs_rise_s),
    .fall_o  (hs_fall_s)
  );

  // One flop deeper than the raw chain so the byte lines up with the PLK edge strobe.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      for (int i = 0; i < SYNC_STAGES + 1; i++) d_sync_q[i] <= '0;
    end else begin
      d_sync_q[0] <= i_D;
      for (int i = 1; i < SYNC_STAGES + 1; i++) d_sync_q[i] <= d_sync_q[i-1];
    end
  end

  assign byte_s = d_sync_q[SYNC_STAGES];

  always_comb begin
    byte_ok_s  = plk_rise_s & ~vs_lvl_s & hs_lvl_s & ~drop_q;
    pix_done_s = byte_ok_s & ((mode_q == MODE_Y8) | phase_q);
    if (mode_q == MODE_Y8) begin
      word_d = {{DATA_W{1'b0}}, byte_s};
    end else begin
      word_d = {hi_q, byte_s};
    end
  end

  // Capture FSM; an error set in the same cycle as a clear wins because it is assigned last.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_Y8;
      phase_q <= 1'b0;
      hi_q    <= '0;
      pix_q   <= '0;
      drop_q  <= 1'b0;
      we_q    <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      fcnt_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      if (i_Clear_Err) err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_Enable) state_q <= WAIT_VS;
        end
        WAIT_VS: begin
          if (!i_Enable) begin
            state_q <= IDLE;
          end else if (vs_fall_s) begin
            state_q <= CAPTURE;
            mode_q  <= i_Mode;
            pix_q   <= '0;
            phase_q <= 1'b0;
            drop_q  <= 1'b0;
          end
        end
        CAPTURE: begin
          if (vs_rise_s) begin
            done_q  <= 1'b1;
            fcnt_q  <= fcnt_q + 8'd1;
            if (pix_q != PIX_FULL) err_q <= 1'b1;
            pix_q   <= '0;
            phase_q <= 1'b0;
            drop_q  <= 1'b0;
            state_q <= i_Enable ? WAIT_VS : IDLE;
          end else if (hs_rise_s | hs_fall_s) begin
            phase_q <= 1'b0;
          end else if (byte_ok_s) begin
            if (mode_q == MODE_RGB565) phase_q <= ~phase_q;
            if (!pix_done_s) begin
              hi_q <= byte_s;
            end else if (pix_q == PIX_FULL) begin
              err_q  <= 1'b1;
              drop_q <= 1'b1;
            end else begin
              we_q   <= 1'b1;
              data_q <= word_d;
              addr_q <= pix_q[ADDR_W-1:0];
              pix_q  <= pix_q + PIX_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_XLK              = xlk_q;
  assign o_RAM_Data         = data_q;
  assign o_RAM_Address      = addr_q;
  assign o_RAM_Write_Enable = we_q;
  assign o_Frame_Done       = done_q;
  assign o_Frame_Count      = fcnt_q;
  assign o_Error            = err_q;

endmodule
